vreg_read_collector: RTL and testbench
======================================

# vreg_read_collector

- Operand-collection stage directly upstream of the four per-bank read arbiters in the vector register file.
- Latches one batch of up to PORT_NUM read requests and broadcasts the latched addresses to all bank arbiters.
- Drives the per-port served mask back into the arbiters each cycle and captures bank read data one cycle after each grant.
- Once every enabled port holds its operand, presents the complete operand set downstream with a valid/ready handshake.

## Interface
- PORT_NUM, 5, number of vector read ports per batch
- BANK_NUM, 4, number of register banks (bank id = {addr[0], addr[ADDR_WIDTH-1]})
- READ_BANK_PORT, 2, read ports per bank
- ADDR_WIDTH, 6, vector register address width
- DATA_WIDTH, 128, bits per register read
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of the current batch
- req_valid  in  1  batch request valid
- req_ready  out  1  collector can accept a batch
- req_port_en  in  PORT_NUM  ports carrying an operand in this batch
- req_addr  in  PORT_NUM×ADDR_WIDTH  register address per port
- vreg_addr  out  PORT_NUM×ADDR_WIDTH  latched addresses, broadcast to every arbiter
- vreg_read_select  out  PORT_NUM  1 = port served or disabled (arbiter must not request it)
- bank_read_select  in  BANK_NUM×PORT_NUM  per-bank grant mask this cycle
- prio_idx  in  BANK_NUM×READ_BANK_PORT×PORT_NUM  one-hot port granted on each bank read port
- bank_rdata  in  BANK_NUM×READ_BANK_PORT×DATA_WIDTH  bank read data, valid the cycle after its grant
- rsp_valid  out  1  operand set complete
- rsp_data  out  PORT_NUM×DATA_WIDTH  operand per port (zero for disabled ports)
- rsp_ready  in  1  consumer accepts operand set

## Operation
**States:** IDLE, COLLECT, DRAIN, RESP.

**IDLE**
- req_ready=1.
- On req_valid, latch req_addr into vreg_addr and latch port_en.
- Clear served and the operand buffer.
- If port_en≠0, go to COLLECT; if port_en=0, go to RESP.

**COLLECT**
- vreg_read_select = ~port_en | served.
- Compute grant = OR over banks of bank_read_select.
- Update served |= grant.
- Register prio_idx into gnt_q with a gnt_vld flag.
- If (served | grant) covers port_en, go to DRAIN; otherwise stay.

**Data capture (every cycle gnt_vld=1, any state)**
- For each bank b, read port r, and port j with gnt_q[b][r][j]=1: buf[j] <= bank_rdata[b][r].

**DRAIN**
- Captures the final grant's data.
- vreg_read_select = all ones.
- Go to RESP.

**RESP**
- rsp_valid=1, rsp_data=buf, vreg_read_select = all ones.
- On rsp_ready, go to IDLE; req_ready stays 0 in this cycle.

**Flush**
- flush=1 in any state: next state IDLE.
- Clears served, gnt_vld and rsp_valid.
- Data arriving the following cycle is discarded.
- flush has priority over req_valid and rsp_ready.

**Reset values**
- State IDLE; req_ready=1; rsp_valid=0; rsp_data=0.
- vreg_addr=0; vreg_read_select = all ones; gnt_vld=0.

**Error conditions (flagged by simulation assertions)**
- A port granted by two banks in one cycle.
- A grant to a port that is already served or disabled.
- A non-one-hot prio_idx entry.
- Design response to any of these: treat grants as OR, last-bank data wins.

## Timing
- Accept edge E0. COLLECT occupies cycles 1..k, where k = max over banks of ceil(hits/READ_BANK_PORT).
- DRAIN occupies cycle k+1; rsp_valid rises in cycle k+2.
- Minimum accept-to-rsp_valid latency is 3 cycles; with port_en=0 it is 1 cycle.
- rsp_valid, rsp_data and vreg_addr are stable while rsp_valid=1 && rsp_ready=0.
- Throughput: the next batch is accepted no earlier than the cycle after the rsp handshake.
- No combinational path from req_valid or rsp_ready to any output except through state registers.
- vreg_read_select is combinational from registered state only.

## Test plan
- **All-bank spread:** port_en=5'h1F, addrs 0x00,0x01,0x20,0x21,0x02 (banks 0,2,1,3,0), bench returns data = {addr, ~addr} per read → single COLLECT cycle, rsp_valid 3 cycles after accept, rsp_data[j] matches each port's address.
- **Single-bank conflict:** addrs 0x00,0x02,0x04,0x06,0x08 → grants 2/2/1 over 3 COLLECT cycles, vreg_read_select 5'h00→5'h03→5'h0F→5'h1F, rsp_valid in cycle 5.
- **Partial enable:** port_en=5'h05 → vreg_read_select starts 5'h1A and rsp_data[1,3,4]=0; port_en=0 → rsp_valid in cycle 1 with all-zero data.
- **Backpressure:** rsp_ready held low 4 cycles → rsp_valid, rsp_data stable and req_ready=0 throughout; release → IDLE next cycle, back-to-back batch accepted.
- **Flush:** flush in the 2nd COLLECT cycle and again in DRAIN → IDLE next cycle, no rsp_valid, a subsequent batch returns only its own data.
- **Reset:** rst_n asserted mid-COLLECT → all outputs at reset values immediately, a new batch completes correctly after release.

Source files
------------

// File: rtl/vreg_read_collector.sv
// vreg_read_collector: latches a batch of vector register reads, steers bank grants and returns the collected operand set.
module vreg_read_collector #(
    parameter int PORT_NUM       = 5,
    parameter int BANK_NUM       = 4,
    parameter int READ_BANK_PORT = 2,
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 128
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          flush,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [PORT_NUM-1:0]                           req_port_en,
    input  logic [PORT_NUM*ADDR_WIDTH-1:0]                req_addr,
    output logic [PORT_NUM*ADDR_WIDTH-1:0]                vreg_addr,
    output logic [PORT_NUM-1:0]                           vreg_read_select,
    input  logic [BANK_NUM*PORT_NUM-1:0]                  bank_read_select,
    input  logic [BANK_NUM*READ_BANK_PORT*PORT_NUM-1:0]   prio_idx,
    input  logic [BANK_NUM*READ_BANK_PORT*DATA_WIDTH-1:0] bank_rdata,
    output logic                                          rsp_valid,
    output logic [PORT_NUM*DATA_WIDTH-1:0]                rsp_data,
    input  logic                                          rsp_ready
);
    localparam int RP = BANK_NUM * READ_BANK_PORT;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, RESP} state_t;
    state_t                         state_q, state_d;
    logic [PORT_NUM-1:0]            port_en_q, port_en_d, served_q, served_d, grant;
    logic [PORT_NUM*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PORT_NUM*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [RP*PORT_NUM-1:0]         gnt_q, gnt_d;
    logic                           gnt_vld_q, gnt_vld_d;
    logic                           dup, prio_bad;
    always_comb begin
        grant    = '0;
        dup      = 1'b0;
        prio_bad = 1'b0;
        for (int b = 0; b < BANK_NUM; b++) begin
            dup   = dup | (|(grant & bank_read_select[b*PORT_NUM +: PORT_NUM]));
            grant = grant | bank_read_select[b*PORT_NUM +: PORT_NUM];
        end
        for (int i = 0; i < RP; i++)
            prio_bad = prio_bad | !$onehot0(prio_idx[i*PORT_NUM +: PORT_NUM]);
    end
    always_comb begin
        state_d   = state_q;
        port_en_d = port_en_q;
        served_d  = served_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        gnt_d     = gnt_q;
        gnt_vld_d = 1'b0;
        if (gnt_vld_q)
            for (int i = 0; i < RP; i++)
                for (int j = 0; j < PORT_NUM; j++)
                    if (gnt_q[i*PORT_NUM + j])
                        buf_d[j*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d    = req_addr;
                port_en_d = req_port_en;
                served_d  = '0;
                buf_d     = '0;
                state_d   = |req_port_en ? COLLECT : RESP;
            end
            COLLECT: begin
                served_d  = served_q | grant;
                gnt_d     = prio_idx;
                gnt_vld_d = 1'b1;
                state_d   = (((served_q | grant) & port_en_q) == port_en_q) ? DRAIN : COLLECT;
            end
            DRAIN:   state_d = RESP;
            default: state_d = rsp_ready ? IDLE : RESP;
        endcase
        if (flush) begin
            state_d   = IDLE;
            served_d  = '0;
            gnt_vld_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            port_en_q <= '0;
            served_q  <= '0;
            addr_q    <= '0;
            buf_q     <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_en_q <= port_en_d;
            served_q  <= served_d;
            addr_q    <= addr_d;
            buf_q     <= buf_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end
    assign req_ready        = state_q == IDLE;
    assign rsp_valid        = state_q == RESP;
    assign rsp_data         = buf_q;
    assign vreg_addr        = addr_q;
    assign vreg_read_select = (state_q == COLLECT) ? (~port_en_q | served_q) : '1;
    a_no_dup_grant: assert property (@(posedge clk) disable iff (!rst_n) state_q == COLLECT |-> !dup);
    a_no_stale_grant: assert property (@(posedge clk) disable iff (!rst_n)
        state_q == COLLECT |-> (grant & (served_q | ~port_en_q)) == '0);
    a_prio_onehot: assert property (@(posedge clk) disable iff (!rst_n) state_q == COLLECT |-> !prio_bad);
endmodule

// File: tb/tb_vreg_read_collector.sv
// tb_vreg_read_collector: directed checks of batch collection, conflicts, backpressure, flush and reset.
module tb_vreg_read_collector;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [4:0]     req_port_en = '0;
    logic [29:0]    req_addr = '0;
    logic [29:0]    vreg_addr;
    logic [4:0]     vreg_read_select;
    logic [19:0]    bank_read_select;
    logic [39:0]    prio_idx;
    logic [1023:0]  bank_rdata;
    logic           rsp_valid;
    logic [639:0]   rsp_data;
    logic           rsp_ready = 1'b0;
    int             n_tests = 0;
    int             n_fail = 0;
    int             cnt;
    logic [5:0]     ta;
    logic [5:0]     ga [4][2];
    logic [5:0]     rd_q [4][2];
    localparam logic [29:0] A_SPREAD = {6'h02, 6'h21, 6'h20, 6'h01, 6'h00};
    localparam logic [29:0] A_CONF   = {6'h08, 6'h06, 6'h04, 6'h02, 6'h00};
    localparam logic [29:0] A_PART   = {6'h3F, 6'h3F, 6'h01, 6'h3F, 6'h21};
    localparam logic [29:0] A_NEW    = {6'h3F, 6'h3F, 6'h3F, 6'h03, 6'h22};

    vreg_read_collector dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_port_en(req_port_en), .req_addr(req_addr),
        .vreg_addr(vreg_addr), .vreg_read_select(vreg_read_select),
        .bank_read_select(bank_read_select), .prio_idx(prio_idx), .bank_rdata(bank_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input logic [5:0] a);
        return {26'h0, a, 90'h0, ~a};
    endfunction

    always_comb begin
        bank_read_select = '0;
        prio_idx         = '0;
        cnt              = 0;
        ta               = '0;
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 2; r++)
                ga[b][r] = '0;
        for (int b = 0; b < 4; b++) begin
            cnt = 0;
            for (int j = 0; j < 5; j++) begin
                ta = vreg_addr[j*6 +: 6];
                if (!vreg_read_select[j] && int'({ta[0], ta[5]}) == b && cnt < 2) begin
                    bank_read_select[b*5 + j]  = 1'b1;
                    prio_idx[(b*2 + cnt)*5 + j] = 1'b1;
                    ga[b][cnt] = ta;
                    cnt++;
                end
            end
        end
    end

    always @(posedge clk)
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 2; r++)
                rd_q[b][r] <= ga[b][r];

    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 2; r++)
                bank_rdata[(b*2 + r)*128 +: 128] = pat(rd_q[b][r]);
    end

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] en, input logic [29:0] addrs);
        req_valid   = 1'b1;
        req_port_en = en;
        req_addr    = addrs;
        step();
        req_valid   = 1'b0;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_vreg_addr", vreg_addr, 0);
        chk("rst_sel", vreg_read_select, 5'h1F);
        rst_n = 1'b1;
        step();

        send(5'h1F, A_SPREAD);
        chk("spread_addr", vreg_addr, A_SPREAD);
        chk("spread_sel_c1", vreg_read_select, 5'h00);
        chk("spread_vld_c1", rsp_valid, 0);
        step();
        chk("spread_sel_c2", vreg_read_select, 5'h1F);
        chk("spread_vld_c2", rsp_valid, 0);
        step();
        chk("spread_vld_c3", rsp_valid, 1);
        chk("spread_req_ready_c3", req_ready, 0);
        chk("spread_data", rsp_data, {pat(6'h02), pat(6'h21), pat(6'h20), pat(6'h01), pat(6'h00)});
        ack();
        chk("spread_idle_vld", rsp_valid, 0);
        chk("spread_idle_rdy", req_ready, 1);

        send(5'h1F, A_CONF);
        chk("conf_sel_c1", vreg_read_select, 5'h00);
        step();
        chk("conf_sel_c2", vreg_read_select, 5'h03);
        step();
        chk("conf_sel_c3", vreg_read_select, 5'h0F);
        step();
        chk("conf_sel_c4", vreg_read_select, 5'h1F);
        chk("conf_vld_c4", rsp_valid, 0);
        step();
        chk("conf_vld_c5", rsp_valid, 1);
        chk("conf_data", rsp_data, {pat(6'h08), pat(6'h06), pat(6'h04), pat(6'h02), pat(6'h00)});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_vld", rsp_valid, 1);
            chk("bp_rdy", req_ready, 0);
            chk("bp_addr", vreg_addr, A_CONF);
            chk("bp_data", rsp_data, {pat(6'h08), pat(6'h06), pat(6'h04), pat(6'h02), pat(6'h00)});
        end
        rsp_ready   = 1'b1;
        req_valid   = 1'b1;
        req_port_en = 5'h00;
        req_addr    = '1;
        step();
        rsp_ready = 1'b0;
        chk("bp_rel_vld", rsp_valid, 0);
        chk("bp_rel_rdy", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("empty_vld_c1", rsp_valid, 1);
        chk("empty_data", rsp_data, 0);
        chk("empty_sel", vreg_read_select, 5'h1F);
        chk("empty_addr", vreg_addr, 30'h3FFFFFFF);
        ack();

        send(5'h05, A_PART);
        chk("part_sel_c1", vreg_read_select, 5'h1A);
        step();
        step();
        chk("part_vld_c3", rsp_valid, 1);
        chk("part_data", rsp_data, {128'h0, 128'h0, pat(6'h01), 128'h0, pat(6'h21)});
        ack();

        send(5'h1F, A_CONF);
        step();
        chk("fl1_sel_c2", vreg_read_select, 5'h03);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl1_vld", rsp_valid, 0);
        chk("fl1_rdy", req_ready, 1);
        chk("fl1_sel", vreg_read_select, 5'h1F);
        send(5'h1F, A_SPREAD);
        step();
        chk("fl2_sel_drain", vreg_read_select, 5'h1F);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl2_vld", rsp_valid, 0);
        chk("fl2_rdy", req_ready, 1);
        step();
        chk("fl2_vld_later", rsp_valid, 0);
        send(5'h03, A_NEW);
        step();
        step();
        chk("fl_new_vld", rsp_valid, 1);
        chk("fl_new_data", rsp_data, {128'h0, 128'h0, 128'h0, pat(6'h03), pat(6'h22)});
        ack();

        send(5'h1F, A_CONF);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 1);
        chk("arst_vld", rsp_valid, 0);
        chk("arst_data", rsp_data, 0);
        chk("arst_addr", vreg_addr, 0);
        chk("arst_sel", vreg_read_select, 5'h1F);
        step();
        step();
        rst_n = 1'b1;
        step();
        send(5'h1F, A_SPREAD);
        step();
        step();
        chk("post_rst_vld", rsp_valid, 1);
        chk("post_rst_data", rsp_data, {pat(6'h02), pat(6'h21), pat(6'h20), pat(6'h01), pat(6'h00)});
        ack();
        chk("post_rst_idle", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
